// File: rtl/game_sequencer_pkg.sv
// Shared state codes and field widths for the puck game controller.
package game_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StServe  = 3'd1,
        StPlay   = 3'd2,
        StMissed = 3'd3,
        StOver   = 3'd4
    } state_e;

    localparam int unsigned ScoreW = 16;
    localparam int unsigned SpeedW = 3;
    localparam int unsigned LivesW = 2;

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with per-digit carry, saturating at 9999.
module bcd_counter4 (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] q
);

    logic [15:0] q_next;
    logic        carry;

    always_comb begin
        q_next = q;
        carry  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (q[4*i +: 4] == 4'd9) begin
                    q_next[4*i +: 4] = 4'd0;
                end else begin
                    q_next[4*i +: 4] = q[4*i +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            q <= 16'h0000;
        end else if (inc && q != 16'h9999) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Game-level phase controller: serve/play/miss/over sequencing, lives, speed and BCD score.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int unsigned LIVES        = 3,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned FLASH_FRAMES = 30,
    parameter int unsigned STEP_HITS    = 5,
    parameter int unsigned MAX_SPEED    = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              frame_tick,
    input  logic              hit,
    input  logic              miss,
    output logic              run_en,
    output logic              serve_load,
    output logic [SpeedW-1:0] speed,
    output logic [ScoreW-1:0] score,
    output logic [LivesW-1:0] lives,
    output logic [2:0]        state,
    output logic              flash
);

    localparam int unsigned FrameMax = (SERVE_FRAMES > FLASH_FRAMES) ? SERVE_FRAMES : FLASH_FRAMES;
    localparam int unsigned FrameW   = $clog2(FrameMax + 1);
    localparam int unsigned HitW     = $clog2(STEP_HITS + 1);

    state_e            state_q;
    logic [FrameW-1:0] frame_cnt;
    logic [HitW-1:0]   hit_cnt;
    logic              start_q;
    logic              start_rise;
    logic              new_game;
    logic              score_inc;

    assign start_rise = start & ~start_q;
    assign new_game   = start_rise && (state_q == StIdle || state_q == StOver);
    assign score_inc  = (state_q == StPlay) && hit && !miss;
    assign state      = state_q;

    always_ff @(posedge clk) begin
        // Tracks the button even in reset so a press held across reset release is not an edge.
        start_q    <= start;
        run_en     <= 1'b0;
        serve_load <= 1'b0;
        if (!reset) begin
            state_q   <= StIdle;
            speed     <= SpeedW'(1);
            lives     <= LivesW'(LIVES);
            flash     <= 1'b0;
            frame_cnt <= '0;
            hit_cnt   <= '0;
        end else begin
            case (state_q)
                StIdle, StOver: begin
                    if (new_game) begin
                        state_q    <= StServe;
                        serve_load <= 1'b1;
                        flash      <= 1'b0;
                        speed      <= SpeedW'(1);
                        lives      <= LivesW'(LIVES);
                        hit_cnt    <= '0;
                        frame_cnt  <= '0;
                    end
                end
                StServe: begin
                    if (frame_tick) begin
                        if (frame_cnt == FrameW'(SERVE_FRAMES - 1)) begin
                            state_q   <= StPlay;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                StPlay: begin
                    run_en <= frame_tick;
                    if (miss) begin
                        lives     <= lives - 1'b1;
                        state_q   <= (lives == LivesW'(1)) ? StOver : StMissed;
                        flash     <= 1'b1;
                        frame_cnt <= '0;
                    end else if (hit) begin
                        if (hit_cnt == HitW'(STEP_HITS - 1)) begin
                            hit_cnt <= '0;
                            if (speed != SpeedW'(MAX_SPEED)) speed <= speed + 1'b1;
                        end else begin
                            hit_cnt <= hit_cnt + 1'b1;
                        end
                    end
                end
                StMissed: begin
                    if (frame_tick) begin
                        if (frame_cnt == FrameW'(FLASH_FRAMES - 1)) begin
                            state_q    <= StServe;
                            serve_load <= 1'b1;
                            flash      <= 1'b0;
                            frame_cnt  <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    flash     <= 1'b0;
                    frame_cnt <= '0;
                end
            endcase
        end
    end

    bcd_counter4 u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (new_game),
        .inc   (score_inc),
        .q     (score)
    );

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: a behavioural model queues expected outputs per cycle.
module tb_game_sequencer;

    localparam int SF = 4;
    localparam int FF = 3;
    localparam int SH = 2;
    localparam int LV = 2;
    localparam int MS = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        frame_tick = 1'b0;
    logic        hit = 1'b0;
    logic        miss = 1'b0;
    logic        run_en, serve_load, flash;
    logic [2:0]  speed, state;
    logic [15:0] score;
    logic [1:0]  lives;

    always #5 clk = ~clk;

    game_sequencer #(
        .LIVES        (LV),
        .SERVE_FRAMES (SF),
        .FLASH_FRAMES (FF),
        .STEP_HITS    (SH),
        .MAX_SPEED    (MS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .frame_tick (frame_tick),
        .hit        (hit),
        .miss       (miss),
        .run_en     (run_en),
        .serve_load (serve_load),
        .speed      (speed),
        .score      (score),
        .lives      (lives),
        .state      (state),
        .flash      (flash)
    );

    typedef struct packed {
        logic [2:0]  st;
        logic [15:0] sc;
        logic [2:0]  sp;
        logic [1:0]  lv;
        logic        fl;
        logic        re;
        logic        sl;
    } obs_t;

    obs_t obs;
    assign obs = {state, score, speed, lives, flash, run_en, serve_load};

    obs_t sb[$];
    obs_t e;
    int   n_checks = 0;
    int   n_fail = 0;

    int m_state = 0, m_score = 0, m_speed = 1, m_lives = LV, m_hc = 0, m_fc = 0;
    bit m_sq = 0, m_run = 0, m_sl = 0;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] b;
        int d;
        d = v;
        for (int i = 0; i < 4; i++) begin
            b[4*i +: 4] = 4'(d % 10);
            d = d / 10;
        end
        return b;
    endfunction

    // Drive one cycle of inputs, advance the model and optionally queue the expectation.
    task automatic drive(input bit rn, input bit st, input bit ft, input bit h, input bit m,
                         input bit chk);
        bit rise;
        @(negedge clk);
        reset = rn; start = st; frame_tick = ft; hit = h; miss = m;
        @(posedge clk);
        #1;
        rise = st && !m_sq;
        m_sq = st;
        m_run = 0;
        m_sl = 0;
        if (!rn) begin
            m_state = 0; m_score = 0; m_speed = 1; m_lives = LV; m_hc = 0; m_fc = 0;
        end else begin
            case (m_state)
                0, 4: if (rise) begin
                    m_state = 1; m_score = 0; m_speed = 1; m_lives = LV; m_hc = 0; m_fc = 0;
                    m_sl = 1;
                end
                1: if (ft) begin
                    m_fc++;
                    if (m_fc == SF) begin m_state = 2; m_fc = 0; end
                end
                2: begin
                    m_run = ft;
                    if (m) begin
                        m_lives--;
                        m_state = (m_lives == 0) ? 4 : 3;
                    end else if (h) begin
                        if (m_score < 9999) m_score++;
                        m_hc++;
                        if (m_hc == SH) begin
                            m_hc = 0;
                            if (m_speed < MS) m_speed++;
                        end
                    end
                end
                3: if (ft) begin
                    m_fc++;
                    if (m_fc == FF) begin m_state = 1; m_fc = 0; m_sl = 1; end
                end
                default: m_state = 0;
            endcase
        end
        if (chk) sb.push_back({3'(m_state), to_bcd(m_score), 3'(m_speed), 2'(m_lives),
                               (m_state == 3 || m_state == 4), m_run, m_sl});
    endtask

    task automatic test_reset();
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 1);
        e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL reset: got %h want %h", obs, e); end
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 0, 1);
            e = sb.pop_front(); n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL start_held_%0d: got %h want %h", i, obs, e);
            end
        end
        drive(1, 0, 0, 0, 0, 1);
        e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL start_low: got %h want %h", obs, e); end
    endtask

    task automatic test_serve();
        drive(1, 1, 0, 0, 0, 1);
        e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL serve_entry: got %h want %h", obs, e); end
        drive(1, 1, 0, 0, 0, 1);
        e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL serve_hold: got %h want %h", obs, e); end
        for (int i = 0; i < SF; i++) begin
            drive(1, 0, 1, 0, 0, 1);
            e = sb.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL serve_tick_%0d: got %h want %h", i, obs, e); end
            drive(1, 0, 0, 0, 0, 0);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 0, 0, 1);
            e = sb.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL run_en_hi_%0d: got %h want %h", i, obs, e); end
            drive(1, 0, 0, 0, 0, 1);
            e = sb.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL run_en_lo_%0d: got %h want %h", i, obs, e); end
        end
    endtask

    task automatic test_hits();
        for (int i = 0; i < 7; i++) begin
            drive(1, 0, (i == 2), 1, 0, 1);
            e = sb.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL hit_%0d: got %h want %h", i, obs, e); end
        end
        for (int i = 0; i < 9991; i++) drive(1, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 1, 0, 1);
        e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL score_9999: got %h want %h", obs, e); end
        drive(1, 0, 0, 1, 0, 1);
        e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL score_sat: got %h want %h", obs, e); end
    endtask

    task automatic test_hit_miss();
        drive(1, 0, 0, 1, 1, 1);
        e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL hit_and_miss: got %h want %h", obs, e); end
        for (int i = 0; i < FF; i++) begin
            drive(1, 0, 1, 0, 0, 1);
            e = sb.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL flash_tick_%0d: got %h want %h", i, obs, e); end
            drive(1, 0, 0, 0, 0, 1);
            e = sb.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL flash_gap_%0d: got %h want %h", i, obs, e); end
        end
        for (int i = 0; i < SF; i++) drive(1, 0, 1, 0, 0, 0);
    endtask

    task automatic test_game_over();
        drive(1, 0, 0, 0, 1, 1);
        e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL over_entry: got %h want %h", obs, e); end
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, (i == 2), (i == 0), (i == 1), 1);
            e = sb.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL over_ignore_%0d: got %h want %h", i, obs, e); end
        end
        drive(1, 1, 0, 0, 0, 1);
        e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL over_restart: got %h want %h", obs, e); end
        drive(1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_play();
        for (int i = 0; i < SF; i++) drive(1, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0, 1);
        e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL reset_mid_play: got %h want %h", obs, e); end
        drive(1, 0, 0, 0, 0, 1);
        e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL after_reset: got %h want %h", obs, e); end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_hits();
        test_hit_miss();
        test_game_over();
        test_reset_mid_play();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
